// File: rtl/npc_core.sv
// npc_core: multi-cycle RV32I/E subset core.
// FETCH/DECODE/EXEC/HALT FSM on an external fetch handshake.
module npc_core #(
  parameter int          NR_REGS  = 32,
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_inst,
  output logic [31:0] npc_data,
  output logic [31:0] npc_pc,
  output logic        retire,
  output logic        halt,
  output logic        trap
);

  localparam int AW = (NR_REGS == 16) ? 4 : 5;

  typedef enum logic [1:0] {
    FETCH, DECODE, EXEC, HALT
  } state_t;

  typedef enum logic [3:0] {
    K_ADDI, K_ADD, K_SUB, K_LUI, K_AUIPC,
    K_JAL, K_JALR, K_EBRK, K_ILL
  } kind_t;

  state_t      state;
  kind_t       kind;
  kind_t       dkind;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] opa;
  logic [31:0] opb;
  logic [31:0] imm;
  logic [31:0] dimm;
  logic [31:0] regs [NR_REGS];

  logic [6:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [4:0]  rd_f;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  logic [AW-1:0] ra;
  logic [AW-1:0] rb;
  logic [AW-1:0] wa;
  logic [31:0]   rdata1;
  logic [31:0]   rdata2;

  logic          use_rs1;
  logic          use_rs2;
  logic          use_rd;
  logic          bad_reg;
  logic [31:0]   rd_val;
  logic [31:0]   next_pc;

  assign opc   = inst[6:0];
  assign f3    = inst[14:12];
  assign f7    = inst[31:25];
  assign rd_f  = inst[11:7];
  assign rs1_f = inst[19:15];
  assign rs2_f = inst[24:20];

  assign imm_i = {{20{inst[31]}}, inst[31:20]};
  assign imm_u = {inst[31:12], 12'b0};
  assign imm_j = {{12{inst[31]}}, inst[19:12],
                  inst[20], inst[30:21], 1'b0};

  assign ra = inst[15 +: AW];
  assign rb = inst[20 +: AW];
  assign wa = inst[7 +: AW];

  assign rdata1 = (ra == '0) ? '0 : regs[ra];
  assign rdata2 = (rb == '0) ? '0 : regs[rb];

  assign imem_req_valid = (state == FETCH);
  assign imem_req_addr  = pc;
  assign npc_pc         = pc;

  // Classify the latched word and pick its immediate format.
  always_comb begin
    dkind   = K_ILL;
    dimm    = imm_i;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    use_rd  = 1'b0;
    unique case (1'b1)
      (opc == 7'h13 && f3 == 3'd0): begin
        dkind   = K_ADDI;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h00): begin
        dkind   = K_ADD;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      (opc == 7'h33 && f3 == 3'd0 && f7 == 7'h20): begin
        dkind   = K_SUB;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        use_rd  = 1'b1;
      end
      (opc == 7'h37): begin
        dkind  = K_LUI;
        dimm   = imm_u;
        use_rd = 1'b1;
      end
      (opc == 7'h17): begin
        dkind  = K_AUIPC;
        dimm   = imm_u;
        use_rd = 1'b1;
      end
      (opc == 7'h6f): begin
        dkind  = K_JAL;
        dimm   = imm_j;
        use_rd = 1'b1;
      end
      (opc == 7'h67 && f3 == 3'd0): begin
        dkind   = K_JALR;
        use_rs1 = 1'b1;
        use_rd  = 1'b1;
      end
      (inst == 32'h0010_0073): begin
        dkind = K_EBRK;
      end
      default: begin
        dkind = K_ILL;
      end
    endcase
    bad_reg = (NR_REGS == 16) &&
              ((use_rs1 && rs1_f[4]) ||
               (use_rs2 && rs2_f[4]) ||
               (use_rd  && rd_f[4]));
    if (bad_reg) dkind = K_ILL;
  end

  // Result and successor PC for the decoded instruction.
  always_comb begin
    rd_val  = opa + imm;
    next_pc = pc + 32'd4;
    unique case (kind)
      K_ADDI:  rd_val = opa + imm;
      K_ADD:   rd_val = opa + opb;
      K_SUB:   rd_val = opa - opb;
      K_LUI:   rd_val = imm;
      K_AUIPC: rd_val = pc + imm;
      K_JAL: begin
        rd_val  = pc + 32'd4;
        next_pc = pc + imm;
      end
      K_JALR: begin
        rd_val  = pc + 32'd4;
        next_pc = (opa + imm) & ~32'd1;
      end
      default: ;
    endcase
  end

  // Control FSM with registered status outputs and GPR writeback.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FETCH;
      kind     <= K_ILL;
      pc       <= RESET_PC;
      inst     <= '0;
      opa      <= '0;
      opb      <= '0;
      imm      <= '0;
      npc_data <= '0;
      retire   <= 1'b0;
      halt     <= 1'b0;
      trap     <= 1'b0;
      for (int i = 0; i < NR_REGS; i++) regs[i] <= '0;
    end else begin
      retire <= 1'b0;
      unique case (state)
        FETCH: begin
          if (imem_resp_valid) begin
            inst  <= imem_resp_inst;
            state <= DECODE;
          end
        end
        DECODE: begin
          opa   <= rdata1;
          opb   <= rdata2;
          imm   <= dimm;
          kind  <= dkind;
          state <= EXEC;
        end
        EXEC: begin
          if (kind == K_EBRK || kind == K_ILL) begin
            state <= HALT;
            halt  <= 1'b1;
            trap  <= (kind == K_ILL);
          end else begin
            if (wa != '0) regs[wa] <= rd_val;
            npc_data <= rd_val;
            pc       <= next_pc;
            retire   <= 1'b1;
            state    <= FETCH;
          end
        end
        HALT: ;
      endcase
    end
  end

endmodule

// File: tb/tb_npc_core.sv
// tb_npc_core: directed programs against a scoreboard queue.
// Runs RV32I and RV32E instances side by side on one memory image.
module tb_npc_core;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [6:0] OP_IMM = 7'h13;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] AUIPC  = 7'h17;
  localparam logic [6:0] JALR   = 7'h67;
  localparam logic [31:0] EBRK  = 32'h0010_0073;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] npc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_inst;
  logic [31:0] data;
  logic [31:0] pc;
  logic        retire;
  logic        halt;
  logic        trap;

  logic        e_req_valid;
  logic [31:0] e_req_addr;
  logic        e_resp_valid;
  logic [31:0] e_resp_inst;
  logic [31:0] e_data;
  logic [31:0] e_pc;
  logic        e_retire;
  logic        e_halt;
  logic        e_trap;

  logic [31:0] mem [16];
  int          delay = 0;
  int          wcnt = 0;
  int          e_rcnt = 0;
  int          nvec = 0;
  int          nerr = 0;
  exp_t        q[$];

  npc_core #(.NR_REGS(32), .RESET_PC(BASE)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(req_valid), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_inst(resp_inst),
    .npc_data(data), .npc_pc(pc),
    .retire(retire), .halt(halt), .trap(trap)
  );

  npc_core #(.NR_REGS(16), .RESET_PC(BASE)) dute (
    .clk(clk), .rst(rst),
    .imem_req_valid(e_req_valid), .imem_req_addr(e_req_addr),
    .imem_resp_valid(e_resp_valid), .imem_resp_inst(e_resp_inst),
    .npc_data(e_data), .npc_pc(e_pc),
    .retire(e_retire), .halt(e_halt), .trap(e_trap)
  );

  always #5 clk = ~clk;

  // Instruction memory for the RV32I core, with programmable wait states.
  always_comb begin
    logic [31:0] off;
    off        = req_addr - BASE;
    resp_inst  = (off < 32'd64) ? mem[off[5:2]] : 32'h0;
    resp_valid = req_valid && (wcnt >= delay);
  end

  // Zero-wait instruction memory for the RV32E core.
  always_comb begin
    logic [31:0] off;
    off          = e_req_addr - BASE;
    e_resp_inst  = (off < 32'd64) ? mem[off[5:2]] : 32'h0;
    e_resp_valid = e_req_valid;
  end

  always @(posedge clk) begin
    if (rst || !req_valid || resp_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (rst) e_rcnt <= 0;
    else if (e_retire) e_rcnt <= e_rcnt + 1;
  end

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm, input logic [4:0] rs1,
    input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, 3'b000, rd, op};
  endfunction

  function automatic logic [31:0] enc_r(
    input logic [6:0] f7, input logic [4:0] rs2,
    input logic [4:0] rs1, input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, OP};
  endfunction

  function automatic logic [31:0] enc_u(
    input logic [19:0] imm, input logic [4:0] rd,
    input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6f};
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_valid", {31'b0, req_valid}, 32'd1);
    chk("rst_req_addr", req_addr, BASE);
    chk("rst_pc", pc, BASE);
    chk("rst_data", data, 32'h0);
    chk("rst_retire", {31'b0, retire}, 32'd0);
    chk("rst_halt", {31'b0, halt}, 32'd0);
    chk("rst_trap", {31'b0, trap}, 32'd0);
  endtask

  task automatic wait_retire(input int gap);
    exp_t e;
    int   n;
    logic moved;
    e     = q.pop_front();
    n     = 0;
    moved = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (retire) begin
        n = i;
        break;
      end
      if (req_valid && req_addr !== e.pc) moved = 1'b1;
    end
    chk("retire_gap", 32'(n), 32'(gap));
    chk("req_stable", {31'b0, moved}, 32'd0);
    chk("npc_data", data, e.data);
    chk("npc_pc", pc, e.npc);
  endtask

  task automatic wait_halt(input logic t, input logic [31:0] hpc);
    int r;
    r = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (retire) r++;
      if (halt) break;
    end
    chk("halt", {31'b0, halt}, 32'd1);
    chk("trap", {31'b0, trap}, {31'b0, t});
    chk("halt_no_retire", 32'(r), 32'd0);
    chk("halt_req_valid", {31'b0, req_valid}, 32'd0);
    chk("halt_pc", pc, hpc);
    repeat (4) @(negedge clk);
    chk("halt_sticky", {31'b0, halt}, 32'd1);
    chk("halt_quiet", {31'b0, req_valid | retire}, 32'd0);
  endtask

  task automatic push_prog1();
    q.push_back('{BASE + 32'h00, 32'd5,         BASE + 32'h04});
    q.push_back('{BASE + 32'h04, 32'hFFFF_FFFE, BASE + 32'h08});
    q.push_back('{BASE + 32'h08, 32'd3,         BASE + 32'h0C});
    q.push_back('{BASE + 32'h0C, 32'd7,         BASE + 32'h10});
    q.push_back('{BASE + 32'h10, 32'h1234_5000, BASE + 32'h14});
    q.push_back('{BASE + 32'h14, 32'h8000_1014, BASE + 32'h18});
  endtask

  initial begin
    clear_mem();
    // addi x1,x0,5 ; addi x2,x1,-7 ; add x3 ; sub x4 ; lui ; auipc
    mem[0] = enc_i(12'd5, 5'd0, 5'd1, OP_IMM);
    mem[1] = enc_i(12'hFF9, 5'd1, 5'd2, OP_IMM);
    mem[2] = enc_r(7'h00, 5'd2, 5'd1, 5'd3);
    mem[3] = enc_r(7'h20, 5'd2, 5'd1, 5'd4);
    mem[4] = enc_u(20'h12345, 5'd5, LUI);
    mem[5] = enc_u(20'h00001, 5'd6, AUIPC);
    mem[6] = EBRK;

    delay = 0;
    do_reset();
    push_prog1();
    for (int k = 0; k < 6; k++) wait_retire(3);
    wait_halt(1'b0, BASE + 32'h18);

    delay = 4;
    do_reset();
    push_prog1();
    for (int k = 0; k < 6; k++) wait_retire(7);
    wait_halt(1'b0, BASE + 32'h18);

    // jal x1,+16 ; at +16 jalr x0,0(x1) ; back at +4 addi x9,x0,1
    delay = 0;
    @(negedge clk);
    rst = 1'b1;
    clear_mem();
    mem[0] = enc_j(21'd16, 5'd1);
    mem[1] = enc_i(12'd1, 5'd0, 5'd9, OP_IMM);
    mem[2] = EBRK;
    mem[4] = enc_i(12'd0, 5'd1, 5'd0, JALR);
    do_reset();
    q.push_back('{BASE + 32'h00, BASE + 32'h04, BASE + 32'h10});
    q.push_back('{BASE + 32'h10, BASE + 32'h14, BASE + 32'h04});
    q.push_back('{BASE + 32'h04, 32'd1,         BASE + 32'h08});
    for (int k = 0; k < 3; k++) wait_retire(3);
    wait_halt(1'b0, BASE + 32'h08);

    // addi x15,x0,1 ; addi x17,x0,1 (illegal on RV32E)
    @(negedge clk);
    rst = 1'b1;
    clear_mem();
    mem[0] = enc_i(12'd1, 5'd0, 5'd15, OP_IMM);
    mem[1] = enc_i(12'd1, 5'd0, 5'd17, OP_IMM);
    mem[2] = EBRK;
    do_reset();
    q.push_back('{BASE + 32'h00, 32'd1, BASE + 32'h04});
    q.push_back('{BASE + 32'h04, 32'd1, BASE + 32'h08});
    for (int k = 0; k < 2; k++) wait_retire(3);
    wait_halt(1'b0, BASE + 32'h08);
    chk("e_halt", {31'b0, e_halt}, 32'd1);
    chk("e_trap", {31'b0, e_trap}, 32'd1);
    chk("e_req_valid", {31'b0, e_req_valid}, 32'd0);
    chk("e_retires", 32'(e_rcnt), 32'd1);
    chk("e_data", e_data, 32'd1);
    chk("e_pc", e_pc, BASE + 32'h04);

    do_reset();
    chk("e_rst_halt", {31'b0, e_halt | e_trap}, 32'd0);
    chk("e_rst_pc", e_pc, BASE);

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
